idu_stage: RTL and testbench
============================

# idu_stage

Registered, parametrised successor to the combinational integer decode unit. It accepts raw 32-bit instructions with their PC over a valid/ready handshake and decodes them into ALU control, register specifiers, a sign-extended immediate and an illegal-instruction flag. Results are presented one cycle later through a two-entry skid buffer, so `in_ready` is a register output and the stage sustains one instruction per cycle under backpressure. It sits between fetch and the IEU issue/ALU stage, supports RV32I and RV64I (including the W-ops), and has a pipeline flush input.

## Interface
- `XLEN`, 32: datapath width; 32 or 64 only. Any other value is a build-time error.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  discards all buffered entries and any transfer in the same cycle.
- `in_valid`  in  1  instruction offered.
- `in_ready`  out  1  stage can accept; driven from a register.
- `in_instr`  in  32  raw instruction.
- `in_pc`  in  XLEN  PC of `in_instr`.
- `out_valid`  out  1  decoded instruction present.
- `out_ready`  in  1  consumer accepts.
- `out_pc`  out  XLEN  forwarded PC.
- `out_imm`  out  XLEN  sign-extended immediate, or zero-extended shamt for shifts.
- `out_funct3`  out  3  ALU function.
- `out_funct7`  out  7  ALU function modifier.
- `out_op1_pc`  out  1  ALU op1 is the PC.
- `out_op1_zero`  out  1  ALU op1 is zero (LUI).
- `out_op2_imm`  out  1  ALU op2 is `out_imm`.
- `out_rs1`, `out_rs2`, `out_rd`  out  5 each  raw register fields.
- `out_rd_we`  out  1  instruction writes `rd`.
- `out_word`  out  1  RV64 32-bit op (OP_IMM_32 / OP_32).
- `out_illegal`  out  1  instruction cannot be executed.

## Operation
- Decode is combinational on `in_instr`; the result is captured into an entry together with `in_pc`.
- **Immediates** (sign bit is instr[31]):
  - I: LOAD, JALR, OP_IMM.
  - S: STORE.
  - B: BRANCH; bit 0 is zero.
  - J: JAL; bit 0 is zero.
  - U: AUIPC, LUI; the low 12 bits are zero, sign-extended to XLEN.
- **funct3** is forced to 000 for LOAD, STORE, BRANCH, JALR, JAL, AUIPC and LUI. Otherwise it is instr[14:12].
- **funct7**:
  - OP, OP_32: instr[31:25].
  - OP_IMM and OP_IMM_32 shifts (funct3 001/101): shift imm and funct7 as below.
  - Everything else: 0.
- **Shift imm and funct7 (funct3 001/101):**
  - XLEN=64 OP_IMM: imm = zero-extended instr[25:20]; funct7 = {instr[31:26],0}.
  - XLEN=32 OP_IMM, and OP_IMM_32: imm = zero-extended instr[24:20]; funct7 = instr[31:25].
- **Operand selects:**
  - `op1_pc`: BRANCH, JAL, AUIPC.
  - `op1_zero`: LUI.
  - `op2_imm`: every non-OP/OP_32 opcode except MISC_MEM and SYSTEM.
- **`out_rd_we`:** 1 for LOAD, JAL, JALR, OP_IMM, OP, AUIPC, LUI, OP_IMM_32 and OP_32. It is forced to 0 when rd=0 or when the instruction is illegal.
- **`out_word`:** 1 for OP_IMM_32 and OP_32 when XLEN=64.
- **`out_illegal`** is set when any of the following holds:
  - instr[1:0] ≠ 11;
  - the opcode is not one of the recognised opcodes;
  - OP_IMM_32 or OP_32 with XLEN=32;
  - XLEN=32 shift with instr[25]=1.
- MISC_MEM and SYSTEM decode as legal no-ops: rd_we=0, all selects 0.
- **Buffer:** a main entry M drives the outputs; a skid entry S holds overflow. States:
  - EMPTY: M and S empty.
  - ONE: M full.
  - FULL: M and S full.
- **Transitions** (acc = `in_valid & in_ready`, deq = `out_valid & out_ready`):
  - EMPTY + acc → ONE.
  - ONE + acc & !deq → FULL; the new entry goes to S.
  - ONE + acc & deq → ONE; M takes the new entry.
  - ONE + deq only → EMPTY.
  - FULL + deq → ONE; M takes S.
- `in_ready` is registered as 1 in EMPTY and ONE, and 0 in FULL.
- Program order is always preserved.
- **Flush:** the next state is EMPTY; `in_ready`=1 next cycle. An acceptance in the flush cycle is discarded. `out_valid` is still 1 in the flush cycle if M was full, and a consumer handshake then is permitted.

## Timing
- **Reset values:** `out_valid`=0, all `out_*` payloads 0, `in_ready`=0 while `rst` is high and 1 the cycle after `rst` falls.
- **Latency:** instruction accepted in cycle N appears on outputs in cycle N+1.
- **Throughput:** one instruction per cycle while `out_ready`=1.
- **No combinational paths** from `out_ready` to `in_ready`, or from `in_*` to `out_*`.
- **Payload stability:** outputs hold stable while `out_valid` & !`out_ready`.
- **Reset mid-operation:** clears all entries irrespective of `flush`, `in_valid` and `out_ready`.
- **Priority:** `rst` > `flush` > handshakes.

## Test plan
- XLEN=32, 0xFFF00093 (addi x1,x0,-1) → one cycle later: imm=0xFFFFFFFF, funct3=000, rd=1, rd_we=1, op2_imm=1, illegal=0.
- XLEN=64:
  - 0x123452B7 (lui x5) → imm=0x0000000012345000, op1_zero=1.
  - 0xFE000EE3 (beq x0,x0,-4) → imm=0xFFFFFFFFFFFFFFFC, op1_pc=1, rd_we=0.
- 0x03F09093 (slli x1,x1,63):
  - XLEN=64 → imm=63, funct7=0.
  - XLEN=32 → illegal=1, rd_we=0.
- 0x0010809B (addiw x1,x1,1):
  - XLEN=64 → word=1, imm=1.
  - XLEN=32 → illegal=1.
- Backpressure: send three back-to-back instructions A, B, C with `out_ready`=0 for 3 cycles, then `out_ready`=1:
  - `in_ready` falls after B is accepted.
  - A holds stable on the outputs.
  - A, B, C emerge in order on consecutive cycles.
- Flush and reset:
  - Assert `flush` in the FULL state while `in_valid`=1 → `out_valid`=0 and `in_ready`=1 next cycle; the offered instruction never appears.
  - Repeat the scenario with `rst` instead of `flush` → all outputs are 0.

Source files
------------

// File: rtl/idu_stage.sv
// rtl/idu_stage.sv - registered RV32I/RV64I decode stage with two-entry skid buffer
module idu_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic            out_op1_pc,
    output logic            out_op1_zero,
    output logic            out_op2_imm,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic            out_rd_we,
    output logic            out_word,
    output logic            out_illegal
);
    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("idu_stage: XLEN must be 32 or 64");
        end
    endgenerate

    localparam bit RV64 = (XLEN == 64);

    localparam logic [4:0] OPC_LOAD      = 5'b00000;
    localparam logic [4:0] OPC_MISC_MEM  = 5'b00011;
    localparam logic [4:0] OPC_OP_IMM    = 5'b00100;
    localparam logic [4:0] OPC_AUIPC     = 5'b00101;
    localparam logic [4:0] OPC_OP_IMM_32 = 5'b00110;
    localparam logic [4:0] OPC_STORE     = 5'b01000;
    localparam logic [4:0] OPC_OP        = 5'b01100;
    localparam logic [4:0] OPC_LUI       = 5'b01101;
    localparam logic [4:0] OPC_OP_32     = 5'b01110;
    localparam logic [4:0] OPC_BRANCH    = 5'b11000;
    localparam logic [4:0] OPC_JALR      = 5'b11001;
    localparam logic [4:0] OPC_JAL       = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM    = 5'b11100;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic            op1_pc;
        logic            op1_zero;
        logic            op2_imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            rd_we;
        logic            word;
        logic            illegal;
    } entry_t;

    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} state_t;

    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_j;
    logic [31:0] imm_u;
    logic        is_shift;
    logic        legal;
    logic        writes_rd;
    entry_t      dec;
    entry_t      m_q;
    entry_t      s_q;
    state_t      state;
    logic        acc;
    logic        deq;

    assign imm_i    = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s    = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b    = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_j    = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
    assign imm_u    = {in_instr[31:12], 12'h000};
    assign is_shift = (in_instr[13:12] == 2'b01);

    // Combinational decode of the offered instruction into a buffer entry
    always_comb begin
        dec       = '0;
        legal     = 1'b1;
        writes_rd = 1'b0;
        dec.pc    = in_pc;
        dec.rs1   = in_instr[19:15];
        dec.rs2   = in_instr[24:20];
        dec.rd    = in_instr[11:7];
        case (in_instr[6:2])
            OPC_LOAD: begin
                dec.imm = XLEN'($signed(imm_i));
                dec.op2_imm = 1'b1;
                writes_rd = 1'b1;
            end
            OPC_MISC_MEM: dec.funct3 = in_instr[14:12];
            OPC_OP_IMM, OPC_OP_IMM_32: begin
                dec.funct3 = in_instr[14:12];
                dec.op2_imm = 1'b1;
                writes_rd = 1'b1;
                if (in_instr[6:2] == OPC_OP_IMM_32) begin
                    dec.word = RV64;
                    legal = RV64;
                end
                if (!is_shift) begin
                    dec.imm = XLEN'($signed(imm_i));
                end else if (RV64 && in_instr[6:2] == OPC_OP_IMM) begin
                    // RV64 shifts borrow funct7[0] as shamt[5]
                    dec.imm = XLEN'(in_instr[25:20]);
                    dec.funct7 = {in_instr[31:26], 1'b0};
                end else begin
                    dec.imm = XLEN'(in_instr[24:20]);
                    dec.funct7 = in_instr[31:25];
                    if (!RV64 && in_instr[25]) legal = 1'b0;
                end
            end
            OPC_AUIPC: begin
                dec.imm = XLEN'($signed(imm_u));
                dec.op1_pc = 1'b1;
                dec.op2_imm = 1'b1;
                writes_rd = 1'b1;
            end
            OPC_STORE: begin
                dec.imm = XLEN'($signed(imm_s));
                dec.op2_imm = 1'b1;
            end
            OPC_OP, OPC_OP_32: begin
                dec.funct3 = in_instr[14:12];
                dec.funct7 = in_instr[31:25];
                writes_rd = 1'b1;
                if (in_instr[6:2] == OPC_OP_32) begin
                    dec.word = RV64;
                    legal = RV64;
                end
            end
            OPC_LUI: begin
                dec.imm = XLEN'($signed(imm_u));
                dec.op1_zero = 1'b1;
                dec.op2_imm = 1'b1;
                writes_rd = 1'b1;
            end
            OPC_BRANCH: begin
                dec.imm = XLEN'($signed(imm_b));
                dec.op1_pc = 1'b1;
                dec.op2_imm = 1'b1;
            end
            OPC_JALR: begin
                dec.imm = XLEN'($signed(imm_i));
                dec.op2_imm = 1'b1;
                writes_rd = 1'b1;
            end
            OPC_JAL: begin
                dec.imm = XLEN'($signed(imm_j));
                dec.op1_pc = 1'b1;
                dec.op2_imm = 1'b1;
                writes_rd = 1'b1;
            end
            OPC_SYSTEM: dec.funct3 = in_instr[14:12];
            default: legal = 1'b0;
        endcase
        if (in_instr[1:0] != 2'b11) legal = 1'b0;
        dec.illegal = !legal;
        dec.rd_we   = writes_rd && legal && (in_instr[11:7] != 5'd0);
    end

    assign acc       = in_valid && in_ready;
    assign deq       = out_valid && out_ready;
    assign out_valid = (state != ST_EMPTY);

    // Main/skid buffer FSM; in_ready is registered from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_EMPTY;
            in_ready <= 1'b0;
            m_q      <= '0;
            s_q      <= '0;
        end else if (flush) begin
            state    <= ST_EMPTY;
            in_ready <= 1'b1;
        end else begin
            in_ready <= 1'b1;
            case (state)
                ST_EMPTY: begin
                    if (acc) begin
                        m_q   <= dec;
                        state <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (acc && !deq) begin
                        s_q      <= dec;
                        state    <= ST_FULL;
                        in_ready <= 1'b0;
                    end else if (acc) begin
                        m_q <= dec;
                    end else if (deq) begin
                        state <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    in_ready <= deq;
                    if (deq) begin
                        m_q   <= s_q;
                        state <= ST_ONE;
                    end
                end
                default: state <= ST_EMPTY;
            endcase
        end
    end

    assign out_pc       = m_q.pc;
    assign out_imm      = m_q.imm;
    assign out_funct3   = m_q.funct3;
    assign out_funct7   = m_q.funct7;
    assign out_op1_pc   = m_q.op1_pc;
    assign out_op1_zero = m_q.op1_zero;
    assign out_op2_imm  = m_q.op2_imm;
    assign out_rs1      = m_q.rs1;
    assign out_rs2      = m_q.rs2;
    assign out_rd       = m_q.rd;
    assign out_rd_we    = m_q.rd_we;
    assign out_word     = m_q.word;
    assign out_illegal  = m_q.illegal;
endmodule

// File: tb/tb_idu_stage.sv
// tb/tb_idu_stage.sv - randomized reference-model bench for idu_stage at XLEN 32 and 64
module tb_idu_stage;
    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] imm;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        op1_pc;
        logic        op1_zero;
        logic        op2_imm;
        logic        rd_we;
        logic        word;
        logic        illegal;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
    } exp_t;

    localparam logic [6:0] OPS [13] = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h1B, 7'h23, 7'h33,
                                        7'h37, 7'h3B, 7'h63, 7'h67, 7'h6F, 7'h73};

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [63:0] in_pc;
    logic        out_ready;

    logic        r32, v32, o32_op1_pc, o32_op1_zero, o32_op2_imm, o32_rd_we, o32_word, o32_illegal;
    logic [31:0] o32_pc, o32_imm;
    logic [2:0]  o32_f3;
    logic [6:0]  o32_f7;
    logic [4:0]  o32_rs1, o32_rs2, o32_rd;
    logic        r64, v64, o64_op1_pc, o64_op1_zero, o64_op2_imm, o64_rd_we, o64_word, o64_illegal;
    logic [63:0] o64_pc, o64_imm;
    logic [2:0]  o64_f3;
    logic [6:0]  o64_f7;
    logic [4:0]  o64_rs1, o64_rs2, o64_rd;

    exp_t g32;
    exp_t g64;
    int   n_cmp = 0;
    int   n_bad = 0;

    idu_stage #(.XLEN(32)) dut32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(r32),
        .in_instr(in_instr), .in_pc(in_pc[31:0]), .out_valid(v32), .out_ready(out_ready),
        .out_pc(o32_pc), .out_imm(o32_imm), .out_funct3(o32_f3), .out_funct7(o32_f7),
        .out_op1_pc(o32_op1_pc), .out_op1_zero(o32_op1_zero), .out_op2_imm(o32_op2_imm),
        .out_rs1(o32_rs1), .out_rs2(o32_rs2), .out_rd(o32_rd), .out_rd_we(o32_rd_we),
        .out_word(o32_word), .out_illegal(o32_illegal)
    );

    idu_stage #(.XLEN(64)) dut64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(r64),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(v64), .out_ready(out_ready),
        .out_pc(o64_pc), .out_imm(o64_imm), .out_funct3(o64_f3), .out_funct7(o64_f7),
        .out_op1_pc(o64_op1_pc), .out_op1_zero(o64_op1_zero), .out_op2_imm(o64_op2_imm),
        .out_rs1(o64_rs1), .out_rs2(o64_rs2), .out_rd(o64_rd), .out_rd_we(o64_rd_we),
        .out_word(o64_word), .out_illegal(o64_illegal)
    );

    always #5 clk = ~clk;

    always_comb begin
        g32 = '{pc: {32'b0, o32_pc}, imm: {32'b0, o32_imm}, f3: o32_f3, f7: o32_f7,
                op1_pc: o32_op1_pc, op1_zero: o32_op1_zero, op2_imm: o32_op2_imm,
                rd_we: o32_rd_we, word: o32_word, illegal: o32_illegal,
                rs1: o32_rs1, rs2: o32_rs2, rd: o32_rd};
        g64 = '{pc: o64_pc, imm: o64_imm, f3: o64_f3, f7: o64_f7,
                op1_pc: o64_op1_pc, op1_zero: o64_op1_zero, op2_imm: o64_op2_imm,
                rd_we: o64_rd_we, word: o64_word, illegal: o64_illegal,
                rs1: o64_rs1, rs2: o64_rs2, rd: o64_rd};
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    task automatic cmp(input string w, input exp_t g, input exp_t e);
        check({w, ".pc"}, g.pc, e.pc);
        check({w, ".regs"}, 64'({g.rs1, g.rs2, g.rd}), 64'({e.rs1, e.rs2, e.rd}));
        check({w, ".rd_we"}, 64'(g.rd_we), 64'(e.rd_we));
        check({w, ".illegal"}, 64'(g.illegal), 64'(e.illegal));
        if (!e.illegal) begin
            check({w, ".imm"}, g.imm, e.imm);
            check({w, ".funct"}, 64'({g.f3, g.f7}), 64'({e.f3, e.f7}));
            check({w, ".sel"}, 64'({g.op1_pc, g.op1_zero, g.op2_imm, g.word}),
                  64'({e.op1_pc, e.op1_zero, e.op2_imm, e.word}));
        end
    endtask

    // Reference decode: field values computed arithmetically from the instruction set rules
    function automatic exp_t model(input logic [31:0] x, input logic [63:0] pc, input bit rv64);
        exp_t   e;
        longint imm;
        bit     wr;
        bit     ok;
        bit     shift;
        e     = '0;
        imm   = 0;
        wr    = 0;
        ok    = 1;
        shift = (x[14:12] == 3'd1) || (x[14:12] == 3'd5);
        e.pc  = rv64 ? pc : {32'b0, pc[31:0]};
        e.rs1 = x[19:15];
        e.rs2 = x[24:20];
        e.rd  = x[11:7];
        case (x[6:0])
            7'h03: begin imm = longint'(x[31:20]) - (x[31] ? 4096 : 0); e.op2_imm = 1; wr = 1; end
            7'h0F: e.f3 = x[14:12];
            7'h13, 7'h1B: begin
                e.f3 = x[14:12]; e.op2_imm = 1; wr = 1;
                if (x[6:0] == 7'h1B) begin ok = rv64; e.word = rv64; end
                if (!shift) imm = longint'(x[31:20]) - (x[31] ? 4096 : 0);
                else if (rv64 && x[6:0] == 7'h13) begin imm = longint'(x[25:20]); e.f7 = {x[31:26], 1'b0}; end
                else begin imm = longint'(x[24:20]); e.f7 = x[31:25]; if (!rv64 && x[25]) ok = 0; end
            end
            7'h17: begin imm = longint'({x[31:12], 12'h000}) - (x[31] ? 64'd4294967296 : 0);
                         e.op1_pc = 1; e.op2_imm = 1; wr = 1; end
            7'h23: begin imm = longint'({x[31:25], x[11:7]}) - (x[31] ? 4096 : 0); e.op2_imm = 1; end
            7'h33, 7'h3B: begin
                e.f3 = x[14:12]; e.f7 = x[31:25]; wr = 1;
                if (x[6:0] == 7'h3B) begin ok = rv64; e.word = rv64; end
            end
            7'h37: begin imm = longint'({x[31:12], 12'h000}) - (x[31] ? 64'd4294967296 : 0);
                         e.op1_zero = 1; e.op2_imm = 1; wr = 1; end
            7'h63: begin imm = longint'({x[31], x[7], x[30:25], x[11:8], 1'b0}) - (x[31] ? 8192 : 0);
                         e.op1_pc = 1; e.op2_imm = 1; end
            7'h67: begin imm = longint'(x[31:20]) - (x[31] ? 4096 : 0); e.op2_imm = 1; wr = 1; end
            7'h6F: begin imm = longint'({x[31], x[19:12], x[20], x[30:21], 1'b0}) - (x[31] ? 64'd2097152 : 0);
                         e.op1_pc = 1; e.op2_imm = 1; wr = 1; end
            7'h73: e.f3 = x[14:12];
            default: ok = 0;
        endcase
        e.imm     = rv64 ? 64'(imm) : (64'(imm) & 64'hFFFF_FFFF);
        e.illegal = !ok;
        e.rd_we   = wr && ok && (x[11:7] != 0);
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        int          k;
        r = $urandom;
        k = $urandom_range(0, 14);
        if (k < 13) r[6:0] = OPS[k];
        else if (k == 14) r[6:0] = OPS[$urandom_range(0, 12)] & 7'h7E;
        return r;
    endfunction

    task automatic send(input logic [31:0] ins, input logic [63:0] pc);
        @(negedge clk);
        in_valid = 1; in_instr = ins; in_pc = pc; out_ready = 1;
        @(negedge clk);
        in_valid = 0;
        check("send.v32", 64'(v32), 64'd1);
        check("send.v64", 64'(v64), 64'd1);
    endtask

    exp_t q32[$];
    exp_t q64[$];
    bit   rdy_ok;
    bit   zero_pl;
    bit   acc;
    bit   deq;

    initial begin
        clk = 0; rst = 1; flush = 0; in_valid = 0; in_instr = 0; in_pc = 0; out_ready = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.in_ready32", 64'(r32), 64'd0);
        check("rst.in_ready64", 64'(r64), 64'd0);
        check("rst.out_valid", 64'({v32, v64}), 64'd0);
        cmp("rst32", g32, '0);
        cmp("rst64", g64, '0);
        rst = 0;
        @(negedge clk);
        check("post_rst.in_ready", 64'({r32, r64}), 64'd3);

        send(32'hFFF00093, 64'h1000);
        check("addi.imm32", 64'(o32_imm), 64'hFFFF_FFFF);
        check("addi.f3", 64'(o32_f3), 64'd0);
        check("addi.rd", 64'(o32_rd), 64'd1);
        check("addi.rd_we", 64'(o32_rd_we), 64'd1);
        check("addi.op2_imm", 64'(o32_op2_imm), 64'd1);
        check("addi.illegal", 64'(o32_illegal), 64'd0);
        send(32'h123452B7, 64'h1004);
        check("lui.imm64", o64_imm, 64'h0000_0000_1234_5000);
        check("lui.op1_zero", 64'(o64_op1_zero), 64'd1);
        send(32'hFE000EE3, 64'h1008);
        check("beq.imm64", o64_imm, 64'hFFFF_FFFF_FFFF_FFFC);
        check("beq.op1_pc", 64'(o64_op1_pc), 64'd1);
        check("beq.rd_we", 64'(o64_rd_we), 64'd0);
        send(32'h03F09093, 64'h100C);
        check("slli.imm64", o64_imm, 64'd63);
        check("slli.f7_64", 64'(o64_f7), 64'd0);
        check("slli.illegal32", 64'(o32_illegal), 64'd1);
        check("slli.rd_we32", 64'(o32_rd_we), 64'd0);
        send(32'h0010809B, 64'h1010);
        check("addiw.word64", 64'(o64_word), 64'd1);
        check("addiw.imm64", o64_imm, 64'd1);
        check("addiw.illegal32", 64'(o32_illegal), 64'd1);

        // Backpressure: A, B, C offered back to back while the consumer stalls
        @(negedge clk);
        in_valid = 1; in_instr = 32'h00100093; in_pc = 64'h200; out_ready = 0;
        @(negedge clk);
        check("bp.a_out", o64_pc, 64'h200);
        check("bp.ready1", 64'(r64), 64'd1);
        in_pc = 64'h204;
        @(negedge clk);
        check("bp.ready_fall", 64'(r64), 64'd0);
        check("bp.a_hold", o64_pc, 64'h200);
        in_pc = 64'h208;
        @(negedge clk);
        check("bp.a_hold2", o64_pc, 64'h200);
        out_ready = 1;
        @(negedge clk);
        check("bp.b_out", o64_pc, 64'h204);
        check("bp.ready_back", 64'(r64), 64'd1);
        @(negedge clk);
        check("bp.c_out", o64_pc, 64'h208);
        in_valid = 0;
        @(negedge clk);
        check("bp.drained", 64'(v64), 64'd0);

        rdy_ok = 0; zero_pl = 1;
        for (int cyc = 0; cyc < 5000; cyc++) begin
            @(negedge clk);
            if (cyc > 0) begin
                check("out_valid32", 64'(v32), 64'(q32.size() != 0));
                check("out_valid64", 64'(v64), 64'(q64.size() != 0));
                check("in_ready32", 64'(r32), 64'(rdy_ok && q32.size() < 2));
                check("in_ready64", 64'(r64), 64'(rdy_ok && q64.size() < 2));
                if (q32.size() != 0) begin
                    cmp("x32", g32, q32[0]);
                    cmp("x64", g64, q64[0]);
                end else if (zero_pl) begin
                    cmp("z32", g32, '0);
                    cmp("z64", g64, '0);
                end
            end
            rst       = (cyc < 2) || ($urandom_range(0, 149) == 0);
            flush     = ($urandom_range(0, 24) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_instr  = rand_instr();
            in_pc     = {$urandom, $urandom};
            out_ready = ($urandom_range(0, 2) != 0);
            @(posedge clk);
            acc = in_valid && rdy_ok && (q32.size() < 2);
            deq = out_ready && (q32.size() != 0);
            if (rst) begin
                q32.delete(); q64.delete(); rdy_ok = 0; zero_pl = 1;
            end else begin
                rdy_ok = 1;
                if (flush) begin
                    q32.delete(); q64.delete();
                end else begin
                    if (deq) begin void'(q32.pop_front()); void'(q64.pop_front()); end
                    if (acc) begin
                        q32.push_back(model(in_instr, in_pc, 1'b0));
                        q64.push_back(model(in_instr, in_pc, 1'b1));
                        zero_pl = 0;
                    end
                end
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
